// File: rtl/apb_text_writer.sv
// APB master that turns a byte stream into read-modify-write accesses on a 80x30 text char map.
// Optional colour-map writes are enabled with the APB_TEXT_WRITER_COLOR_EN macro.
module apb_text_writer #(
  parameter int unsigned APB_ADDR_WIDTH = 14,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 30,
  parameter int unsigned COL_MAP_BASE   = 600
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ch_valid_i,
  input  logic [7:0]                ch_data_i,
  input  logic [7:0]                ch_attr_i,
  output logic                      ch_ready_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  output logic [4:0]                cursor_row_o,
  output logic [6:0]                cursor_col_o,
  output logic                      err_o
);

  localparam int unsigned IDX_W     = 12;
  localparam int unsigned WORD_W    = 10;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned LAST_WORD = ROWS * COLS / 4 - 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SETUP,
    ST_RD_ACCESS,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_CLR_SETUP,
    ST_CLR_ACCESS,
    ST_CRD_SETUP,
    ST_CRD_ACCESS,
    ST_CWR_SETUP,
    ST_CWR_ACCESS
  } state_e;

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [7:0]                ch_q, ch_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [WORD_W-1:0]         cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      ready_q, ready_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  logic [IDX_W-1:0]          cur_idx;
  logic [ROW_W-1:0]          row_inc;
  logic                      advance;
  logic                      clr_col;

`ifdef APB_TEXT_WRITER_COLOR_EN
  logic [7:0]                attr_q, attr_d;
  logic                      clr_col_q, clr_col_d;
  assign clr_col = clr_col_q;
`else
  logic                      unused_attr;
  assign unused_attr = ^ch_attr_i;
  assign clr_col     = 1'b0;
`endif

  // Word address in the char map, or in the colour map when color is set.
  function automatic logic [APB_ADDR_WIDTH-1:0] word_addr(input logic [WORD_W-1:0] w,
                                                           input logic color);
    if (color) word_addr = APB_ADDR_WIDTH'(COL_MAP_BASE) + APB_ADDR_WIDTH'(w);
    else       word_addr = APB_ADDR_WIDTH'(w);
  endfunction

  function automatic logic [APB_DATA_WIDTH-1:0] put_byte(input logic [APB_DATA_WIDTH-1:0] w,
                                                          input logic [LANE_W-1:0] lane,
                                                          input logic [7:0] b);
    logic [APB_DATA_WIDTH-1:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    put_byte = r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      ch_q      <= '0;
      word_q    <= '0;
      lane_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
`ifdef APB_TEXT_WRITER_COLOR_EN
      attr_q    <= '0;
      clr_col_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ch_q      <= ch_d;
      word_q    <= word_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
`ifdef APB_TEXT_WRITER_COLOR_EN
      attr_q    <= attr_d;
      clr_col_q <= clr_col_d;
`endif
    end
  end

  // Next state, cursor and the APB bus values for the coming cycle.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    ch_d     = ch_q;
    word_d   = word_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    advance  = 1'b0;
`ifdef APB_TEXT_WRITER_COLOR_EN
    attr_d    = attr_q;
    clr_col_d = clr_col_q;
`endif
    cur_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
    row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (ch_valid_i) begin
          ch_d = ch_data_i;
`ifdef APB_TEXT_WRITER_COLOR_EN
          attr_d = ch_attr_i;
`endif
          case (ch_data_i)
            8'h0A: begin
              col_d = '0;
              row_d = row_inc;
            end
            8'h0D: col_d = '0;
            8'h0C: begin
              cnt_d    = '0;
              paddr_d  = '0;
              pwdata_d = '0;
              pwrite_d = 1'b1;
              state_d  = ST_CLR_SETUP;
`ifdef APB_TEXT_WRITER_COLOR_EN
              clr_col_d = 1'b0;
`endif
            end
            default: begin
              word_d   = cur_idx[IDX_W-1:LANE_W];
              lane_d   = cur_idx[LANE_W-1:0];
              paddr_d  = word_addr(cur_idx[IDX_W-1:LANE_W], 1'b0);
              pwrite_d = 1'b0;
              state_d  = ST_RD_SETUP;
            end
          endcase
        end
      end
      ST_RD_SETUP: state_d = ST_RD_ACCESS;
      ST_RD_ACCESS: begin
        if (apb_pready_i) begin
          err_d    = err_q | apb_pslverr_i;
          pwdata_d = put_byte(apb_prdata_i, lane_q, ch_q);
          pwrite_d = 1'b1;
          state_d  = ST_WR_SETUP;
        end
      end
      ST_WR_SETUP: state_d = ST_WR_ACCESS;
      ST_WR_ACCESS: begin
        if (apb_pready_i) begin
          err_d = err_q | apb_pslverr_i;
`ifdef APB_TEXT_WRITER_COLOR_EN
          paddr_d  = word_addr(word_q, 1'b1);
          pwrite_d = 1'b0;
          state_d  = ST_CRD_SETUP;
`else
          advance = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef APB_TEXT_WRITER_COLOR_EN
      ST_CRD_SETUP: state_d = ST_CRD_ACCESS;
      ST_CRD_ACCESS: begin
        if (apb_pready_i) begin
          err_d    = err_q | apb_pslverr_i;
          pwdata_d = put_byte(apb_prdata_i, lane_q, attr_q);
          pwrite_d = 1'b1;
          state_d  = ST_CWR_SETUP;
        end
      end
      ST_CWR_SETUP: state_d = ST_CWR_ACCESS;
      ST_CWR_ACCESS: begin
        if (apb_pready_i) begin
          err_d   = err_q | apb_pslverr_i;
          advance = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_CLR_SETUP: state_d = ST_CLR_ACCESS;
      ST_CLR_ACCESS: begin
        if (apb_pready_i) begin
          err_d = err_q | apb_pslverr_i;
          if (cnt_q == WORD_W'(LAST_WORD)) begin
`ifdef APB_TEXT_WRITER_COLOR_EN
            if (!clr_col_q) begin
              clr_col_d = 1'b1;
              cnt_d     = '0;
              paddr_d   = word_addr(WORD_W'(0), 1'b1);
              state_d   = ST_CLR_SETUP;
            end else begin
              row_d   = '0;
              col_d   = '0;
              state_d = ST_IDLE;
            end
`else
            row_d   = '0;
            col_d   = '0;
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d   = cnt_q + WORD_W'(1);
            paddr_d = word_addr(cnt_q + WORD_W'(1), clr_col);
            state_d = ST_CLR_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cursor step after a printable byte; no scrolling, bottom-right wraps to 0,0.
    if (advance) begin
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    ready_d   = (state_d == ST_IDLE);
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_RD_ACCESS) || (state_d == ST_WR_ACCESS) ||
                (state_d == ST_CLR_ACCESS)
`ifdef APB_TEXT_WRITER_COLOR_EN
                || (state_d == ST_CRD_ACCESS) || (state_d == ST_CWR_ACCESS)
`endif
                ;
  end

  assign ch_ready_o    = ready_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign cursor_row_o  = row_q;
  assign cursor_col_o  = col_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_apb_text_writer.sv
// Self-checking bench for apb_text_writer: APB slave model, transaction scoreboard,
// a vector table of bytes, and hand sequences for wrap, clear, error and reset.
module tb_apb_text_writer;

`ifdef APB_TEXT_WRITER_COLOR_EN
  localparam bit COLOR = 1'b1;
`else
  localparam bit COLOR = 1'b0;
`endif
  localparam int READY_LAT = COLOR ? 9 : 5;
  localparam logic [7:0] ATTR = 8'h5C;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = '0;
  logic [7:0]  ch_attr = ATTR;
  logic        ch_ready_o;
  logic [13:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [4:0]  row_o;
  logic [6:0]  col_o;
  logic        err_o;

  always #5 clk = ~clk;

  apb_text_writer dut (
    .clk_i(clk), .rst_i(rst_i),
    .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_attr_i(ch_attr), .ch_ready_o(ch_ready_o),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pwrite_o(pwrite),
    .apb_psel_o(psel), .apb_penable_o(penable),
    .apb_prdata_i(prdata), .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .cursor_row_o(row_o), .cursor_col_o(col_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: configurable wait states, fixed read data, optional error on reads.
  logic [31:0] rd_val = '0;
  int          waits = 0;
  bit          slverr_rd = 1'b0;
  int          wcnt = 0;
  assign pready  = psel & penable & (wcnt >= waits);
  assign prdata  = rd_val;
  assign pslverr = pready & slverr_rd & ~pwrite;
  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] addr;
    logic        wr;
    logic [31:0] data;
  } tr_t;
  tr_t exp_q[$];

  int          psel_cnt = 0;
  int          rd_err_cyc = -1;
  int          first_err = -1;
  logic [13:0] su_addr;
  logic [31:0] su_data;
  logic        su_wr;

  // Monitor: completion is visible at the negedge before the completing edge.
  always @(negedge clk) begin
    tr_t t;
    if (psel) psel_cnt++;
    if (err_o === 1'b1 && first_err < 0) first_err = cyc;
    if (psel && !penable) begin
      su_addr = paddr;
      su_data = pwdata;
      su_wr   = pwrite;
    end
    if (psel && penable && pready) begin
      check("access_stable", {paddr, pwdata, pwrite}, {su_addr, su_data, su_wr});
      if (pslverr && rd_err_cyc < 0) rd_err_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer_addr", 64'(paddr), 64'h3FFF_FFFF);
      end else begin
        t = exp_q.pop_front();
        check("xfer_addr", 64'(paddr), 64'(t.addr));
        check("xfer_write", 64'(pwrite), 64'(t.wr));
        if (t.wr) check("xfer_wdata", 64'(pwdata), 64'(t.data));
      end
    end
  end

  int m_row = 0;
  int m_col = 0;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int lane, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[lane*8 +: 8] = b;
    return r;
  endfunction

  task automatic push_tr(input int addr, input logic wr, input logic [31:0] data);
    exp_q.push_back('{addr: 14'(addr), wr: wr, data: data});
  endtask

  task automatic push_colour();
    int idx;
    idx = m_row * 80 + m_col;
    if (COLOR) begin
      push_tr(600 + idx / 4, 1'b0, '0);
      push_tr(600 + idx / 4, 1'b1, put_byte(rd_val, idx % 4, ATTR));
    end
  endtask

  task automatic advance_model();
    if (m_col == 79) begin
      m_col = 0;
      m_row = (m_row + 1) % 30;
    end else begin
      m_col++;
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n = 0;
    while (ch_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ch_ready_o !== 1'b1) check("accept_timeout", 64'(ch_ready_o), 64'd1);
    ch_data  = ch;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (ch_ready_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ch_ready_o !== 1'b1) check("idle_timeout", 64'(ch_ready_o), 64'd1);
  endtask

  // Printable byte with expectations from the cursor model.
  task automatic print_model(input logic [7:0] ch);
    int idx;
    idx = m_row * 80 + m_col;
    push_tr(idx / 4, 1'b0, '0);
    push_tr(idx / 4, 1'b1, put_byte(rd_val, idx % 4, ch));
    push_colour();
    advance_model();
    send(ch);
    wait_idle(200);
  endtask

  task automatic line_feed();
    m_col = 0;
    m_row = (m_row + 1) % 30;
    send(8'h0A);
    wait_idle(20);
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, 64'(row_o), 64'(r));
    check({name, "_col"}, 64'(col_o), 64'(c));
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [31:0] rd;
    int          w;
    bit          apb;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          row;
    int          col;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    vecs[0]  = '{8'h30, 32'hFFFFFFFF, 1, 1'b1, 14'd0,  32'hFFFF30FF, 0, 2};
    vecs[1]  = '{8'h31, 32'hFFFFFFFF, 1, 1'b1, 14'd0,  32'hFF31FFFF, 0, 3};
    vecs[2]  = '{8'h32, 32'hFFFFFFFF, 0, 1'b1, 14'd0,  32'h32FFFFFF, 0, 4};
    vecs[3]  = '{8'h33, 32'hFFFFFFFF, 0, 1'b1, 14'd1,  32'hFFFFFF33, 0, 5};
    vecs[4]  = '{8'h34, 32'hFFFFFFFF, 0, 1'b1, 14'd1,  32'hFFFF34FF, 0, 6};
    vecs[5]  = '{8'h5A, 32'h00000000, 2, 1'b1, 14'd1,  32'h005A0000, 0, 7};
    vecs[6]  = '{8'h0A, 32'h0,        0, 1'b0, 14'd0,  32'h0,        1, 0};
    vecs[7]  = '{8'h41, 32'hAABBCCDD, 1, 1'b1, 14'd20, 32'hAABBCC41, 1, 1};
    vecs[8]  = '{8'h0D, 32'h0,        0, 1'b0, 14'd0,  32'h0,        1, 0};
    vecs[9]  = '{8'h7E, 32'h00000000, 0, 1'b1, 14'd20, 32'h0000007E, 1, 1};
    vecs[10] = '{8'h0A, 32'h0,        0, 1'b0, 14'd0,  32'h0,        2, 0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ch_ready_o), 64'd0);
    check("rst_psel", 64'({psel, penable, pwrite}), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check_cursor("rst", 0, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(ch_ready_o), 64'd1);

    // 'A' with zero-wait slave, plus ready latency
    rd_val = 32'h11223344;
    waits  = 0;
    push_tr(0, 1'b0, '0);
    push_tr(0, 1'b1, 32'h11223341);
    push_colour();
    send(8'h41);
    for (int k = 1; k <= READY_LAT; k++) begin
      @(negedge clk);
      check($sformatf("ready_lat_%0d", k), 64'(ch_ready_o), 64'(k == READY_LAT));
    end
    check_cursor("first_char", 0, 1);
    check("first_char_drained", 64'(exp_q.size()), 64'd0);
    m_col = 1;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      rd_val = vecs[i].rd;
      waits  = vecs[i].w;
      pc     = psel_cnt;
      if (vecs[i].apb) begin
        push_tr(int'(vecs[i].addr), 1'b0, '0);
        push_tr(int'(vecs[i].addr), 1'b1, vecs[i].wdata);
        push_colour();
      end
      send(vecs[i].ch);
      wait_idle(200);
      check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
      check($sformatf("vec%0d_drained", i), 64'(exp_q.size()), 64'd0);
      if (!vecs[i].apb) check($sformatf("vec%0d_no_psel", i), 64'(psel_cnt), 64'(pc));
      m_row = vecs[i].row;
      m_col = vecs[i].col;
    end

    // Bottom-right corner and wrap to 0,0
    rd_val = '0;
    waits  = 0;
    repeat (27) line_feed();
    check_cursor("row29", 29, 0);
    for (int c = 0; c < 79; c++) print_model(8'h20 + 8'(c % 64));
    check_cursor("pre_wrap", 29, 79);
    push_tr(599, 1'b0, '0);
    push_tr(599, 1'b1, 32'h42000000);
    push_colour();
    send(8'h42);
    wait_idle(200);
    m_row = 0;
    m_col = 0;
    check_cursor("wrap", 0, 0);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);

    // Line feed from 5,10 creates no bus traffic
    repeat (5) line_feed();
    for (int c = 0; c < 10; c++) print_model(8'h61 + 8'(c));
    check_cursor("at_5_10", 5, 10);
    pc = psel_cnt;
    line_feed();
    check_cursor("lf_5_10", 6, 0);
    check("lf_no_psel", 64'(psel_cnt), 64'(pc));

    // Clear screen
    waits = 0;
    for (int i = 0; i < 600; i++) push_tr(i, 1'b1, '0);
    if (COLOR) for (int i = 0; i < 600; i++) push_tr(600 + i, 1'b1, '0);
    send(8'h0C);
    wait_idle(6000);
    m_row = 0;
    m_col = 0;
    check_cursor("clear", 0, 0);
    check("clear_drained", 64'(exp_q.size()), 64'd0);

    // Slave error on the read: sticky err, write still issued
    check("err_before", 64'(err_o), 64'd0);
    rd_val    = 32'h01020304;
    slverr_rd = 1'b1;
    print_model(8'h45);
    slverr_rd = 1'b0;
    check("err_set", 64'(err_o), 64'd1);
    check("err_next_cycle", 64'(first_err), 64'(rd_err_cyc + 1));
    check("err_write_drained", 64'(exp_q.size()), 64'd0);
    rd_val = 32'hCAFEF00D;
    print_model(8'h46);
    check("err_sticky", 64'(err_o), 64'd1);
    check_cursor("after_err", 0, 2);

    // Reset during WR_ACCESS
    waits = 5;
    rd_val = '0;
    push_tr(0, 1'b0, '0);
    push_tr(0, 1'b1, put_byte('0, 2, 8'h47));
    push_colour();
    send(8'h47);
    begin
      int n = 0;
      @(negedge clk);
      while (!(psel && penable && pwrite) && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("reach_wr_access", 64'(psel && penable && pwrite), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_psel", 64'({psel, penable}), 64'd0);
    check_cursor("midrst", 0, 0);
    check("midrst_err", 64'(err_o), 64'd0);
    check("midrst_ready", 64'(ch_ready_o), 64'd0);
    check("midrst_pending", 64'(exp_q.size()), 64'(COLOR ? 3 : 1));
    exp_q.delete();
    rst_i = 1'b0;
    @(negedge clk);
    check("postrst_ready", 64'(ch_ready_o), 64'd1);
    check("postrst_psel", 64'(psel), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
